// File: rtl/wb_host_master.sv
// wb_host_master: turns one host command into one Wishbone classic cycle and returns a response.
// Latency: a command accepted at edge N drives cyc/stb from N; an ack in the first bus cycle gives rsp_valid after N+1.
// Backpressure: cmd_ready is low while busy; a stalled response holds rsp_* and blocks new commands.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_*   host command (we, sel, adr, dat)
//   rsp_valid/rsp_ready/rsp_*   host response (read data, timeout flag)
//   wbm_*                       Wishbone classic initiator port
//   busy                        high whenever a transaction is in flight or unconsumed
module wb_host_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Value of the wait counter during the last permitted bus cycle; the counter
  // starts at zero in the first cycle, so stb stays high exactly TIMEOUT cycles.
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'h0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up one edge after reset release.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= BUS;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
          end
        end

        BUS: begin
          // Ack is tested first so an ack on the final permitted cycle wins over the timeout.
          if (wbm_ack_i || (wait_cnt == LAST_CNT)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ~wbm_ack_i;
            rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'h0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
